// File: rtl/alu_seq_driver.sv
// Stimulus sequencer and golden-model checker for the 4-bit switch-driven ALU.
// Define ALU_SEQ_STOP_ON_ERR_EN to end the sweep at the first mismatching vector.
module alu_seq_driver #(
    parameter int SETTLE = 2,
    parameter int ERR_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [15:0]      sw_out,
    input  logic [15:0]      ledr_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [15:0]      fail_sw,
    output logic [15:0]      fail_ledr
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_DRIVE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [3:0]  WAIT_LAST = 4'(SETTLE - 1);
    localparam logic [10:0] IDX_LAST  = 11'h7FF;

    logic [2:0]  state;
    logic [10:0] idx;
    logic [3:0]  wait_cnt;

    logic [3:0]  a;
    logic [3:0]  b;
    logic [2:0]  func;
    logic [4:0]  add5;
    logic [4:0]  sub5;
    logic [15:0] exp_word;
    logic [15:0] cmp_mask;
    logic        mismatch;

    // The model works off the registered switch word, so it always matches what the ALU sees.
    assign a    = sw_out[3:0];
    assign b    = sw_out[7:4];
    assign func = sw_out[10:8];

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        add5     = {1'b0, a} + {1'b0, b};
        sub5     = {1'b0, a} + {1'b0, ~b} + 5'd1;
        exp_word = '0;
        cmp_mask = 16'hFC00;
        case (func)
            3'b000: begin
                exp_word[4:0] = add5;
                exp_word[5]   = (a[3] == b[3]) && (add5[3] != a[3]);
                cmp_mask[9:0] = '1;
            end
            3'b001: begin
                exp_word[4:0] = sub5;
                exp_word[5]   = (a[3] != b[3]) && (sub5[3] != a[3]);
                cmp_mask[9:0] = '1;
            end
            3'b010: begin
                exp_word[9:6] = ~a;
                cmp_mask[9:6] = '1;
            end
            3'b011: begin
                exp_word[9:6] = a & b;
                cmp_mask[9:6] = '1;
            end
            3'b100: begin
                exp_word[9:6] = a | b;
                cmp_mask[9:6] = '1;
            end
            3'b101: begin
                exp_word[9:6] = a ^ b;
                cmp_mask[9:6] = '1;
            end
            3'b110: begin
                exp_word[6] = $signed(a) < $signed(b);
                cmp_mask[6] = 1'b1;
            end
            default: begin
                exp_word[6] = (a == b);
                cmp_mask[6] = 1'b1;
            end
        endcase
        mismatch = |((ledr_in ^ exp_word) & cmp_mask);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            wait_cnt  <= '0;
            sw_out    <= '0;
            err_cnt   <= '0;
            fail_sw   <= '0;
            fail_ledr <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        idx       <= '0;
                        err_cnt   <= '0;
                        fail_sw   <= '0;
                        fail_ledr <= '0;
                        state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    sw_out   <= {5'b0, idx};
                    wait_cnt <= '0;
                    state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        state <= S_CHECK;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                S_CHECK: begin
                    if (mismatch) begin
                        if (err_cnt != '1) begin
                            err_cnt <= err_cnt + ERR_W'(1);
                        end
                        if (err_cnt == '0) begin
                            fail_sw   <= sw_out;
                            fail_ledr <= ledr_in;
                        end
                    end
`ifdef ALU_SEQ_STOP_ON_ERR_EN
                    if (mismatch || idx == IDX_LAST) begin
`else
                    if (idx == IDX_LAST) begin
`endif
                        state <= S_DONE;
                    end else begin
                        idx   <= idx + 11'd1;
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state register, so reset clears them with it.
    assign busy = (state == S_DRIVE) || (state == S_WAIT) || (state == S_CHECK);
    assign done = (state == S_DONE);
    assign pass = done && (err_cnt == '0);

endmodule

// File: tb/tb_alu_seq_driver.sv
// Directed bench for alu_seq_driver: behavioural ALU with selectable faults plus a
// second instance (ERR_W = 4) facing an ALU stuck at 0xFFFF.
module tb_alu_seq_driver;

`ifdef ALU_SEQ_STOP_ON_ERR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        start4;
    logic [15:0] sw_out, ledr_in, fail_sw, fail_ledr;
    logic        busy, done, pass;
    logic [15:0] err_cnt;
    logic [15:0] sw_out4, ledr4, fail_sw4, fail_ledr4;
    logic        busy4, done4, pass4;
    logic [3:0]  err_cnt4;
    int          mode;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    alu_seq_driver #(.SETTLE(2), .ERR_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .sw_out(sw_out), .ledr_in(ledr_in),
        .busy(busy), .done(done), .pass(pass), .err_cnt(err_cnt),
        .fail_sw(fail_sw), .fail_ledr(fail_ledr)
    );

    alu_seq_driver #(.SETTLE(2), .ERR_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .sw_out(sw_out4), .ledr_in(ledr4),
        .busy(busy4), .done(done4), .pass(pass4), .err_cnt(err_cnt4),
        .fail_sw(fail_sw4), .fail_ledr(fail_ledr4)
    );

    // Behavioural ALU in integer arithmetic. Mode 0 ideal, 1 cout stuck 0 on add,
    // 2 bit 15 set on equality, 3 garbage in every don't-care bit of logic ops.
    function automatic logic [15:0] alu_model(input logic [15:0] sw, input int m);
        int a, b, f, sa, sb, r;
        logic [4:0]  s5;
        logic [3:0]  lg;
        logic        ov;
        logic [15:0] w;
        a  = int'(sw[3:0]);
        b  = int'(sw[7:4]);
        f  = int'(sw[10:8]);
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        s5 = '0;
        lg = '0;
        ov = 1'b0;
        case (f)
            0: begin r = a + b; s5 = 5'(r); ov = (sa + sb > 7) || (sa + sb < -8); end
            1: begin r = a + (15 - b) + 1; s5 = 5'(r); ov = (sa - sb > 7) || (sa - sb < -8); end
            2: lg = 4'(15 - a);
            3: lg = sw[3:0] & sw[7:4];
            4: lg = sw[3:0] | sw[7:4];
            5: lg = sw[3:0] ^ sw[7:4];
            6: lg = {3'b0, sa < sb};
            default: lg = {3'b0, a == b};
        endcase
        w = {6'b0, lg, ov, s5};
        if (m == 1 && f == 0) w[4] = 1'b0;
        if (m == 2 && f == 7) w[15] = 1'b1;
        if (m == 3 && f >= 2 && f <= 5) w[5:0] = 6'h2A;
        if (m == 3 && f >= 6) begin
            w[9:7] = 3'b101;
            w[5:0] = 6'h15;
        end
        return w;
    endfunction

    assign ledr_in = alu_model(sw_out, mode);
    assign ledr4   = 16'hFFFF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts edges after the start edge until done; optionally pokes start at poke_at.
    task automatic wait_done(input int exp_cyc, input int poke_at, input string tag);
        int cyc;
        bit busy_drop;
        cyc = 0;
        busy_drop = 1'b0;
        while (!done && cyc < exp_cyc + 64) begin
            @(negedge clk);
            cyc++;
            start = (cyc == poke_at);
            if (!done && !busy) busy_drop = 1'b1;
        end
        start = 1'b0;
        check({tag, " done cycle"}, 32'(cyc), 32'(exp_cyc));
        check({tag, " busy held"}, 32'(busy_drop), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        start4 = 1'b0;
        mode = 0;
        repeat (2) @(negedge clk);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset pass", 32'(pass), 32'd0);
        check("reset err_cnt", 32'(err_cnt), 32'd0);
        check("reset sw_out", 32'(sw_out), 32'd0);
        check("reset fail_sw", 32'(fail_sw), 32'd0);
        check("reset fail_ledr", 32'(fail_ledr), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle busy", 32'(busy), 32'd0);

        // Clean sweep on dut, saturating sweep on dut4 in parallel.
        start = 1'b1;
        start4 = 1'b1;
        @(negedge clk);
        start = 1'b0;
        start4 = 1'b0;
        check("start busy", 32'(busy), 32'd1);
        check("start done", 32'(done), 32'd0);
        wait_done(8192, -1, "ideal");
        check("ideal pass", 32'(pass), 32'd1);
        check("ideal err_cnt", 32'(err_cnt), 32'd0);
        check("ideal busy", 32'(busy), 32'd0);
        check("ideal fail_sw", 32'(fail_sw), 32'd0);
        check("done4", 32'(done4), 32'd1);
        check("sat err_cnt", 32'(err_cnt4), STOP ? 32'd1 : 32'd15);
        check("sat pass", 32'(pass4), 32'd0);
        check("sat fail_sw", 32'(fail_sw4), 32'h0000);
        check("sat fail_ledr", 32'(fail_ledr4), 32'hFFFF);
        repeat (3) @(negedge clk);
        check("done held", 32'(done), 32'd1);
        check("sw_out held", 32'(sw_out), 32'h07FF);

        // Restart from DONE; a start mid-sweep is ignored.
        pulse_start();
        check("restart done", 32'(done), 32'd0);
        check("restart pass", 32'(pass), 32'd0);
        check("restart busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("restart sw_out", 32'(sw_out), 32'h0000);
        wait_done(8191, 500, "poke");
        check("poke pass", 32'(pass), 32'd1);

        // cout stuck at 0 for add.
        mode = 1;
        pulse_start();
        wait_done(STOP ? 128 : 8192, -1, "cout");
        check("cout err_cnt", 32'(err_cnt), STOP ? 32'd1 : 32'd120);
        check("cout pass", 32'(pass), 32'd0);
        check("cout fail_sw", 32'(fail_sw), 32'h001F);
        check("cout fail_ledr", 32'(fail_ledr), 32'h0000);

        // Reset mid-sweep, asserted together with start: reset wins.
        pulse_start();
        repeat (1000) @(negedge clk);
        check("pre-rst fail_sw", 32'(fail_sw), 32'h001F);
        check("pre-rst err nonzero", 32'(err_cnt != 16'd0), 32'd1);
        rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        start = 1'b0;
        check("rst busy", 32'(busy), 32'd0);
        check("rst sw_out", 32'(sw_out), 32'd0);
        check("rst err_cnt", 32'(err_cnt), 32'd0);
        check("rst done", 32'(done), 32'd0);
        check("rst fail_sw", 32'(fail_sw), 32'd0);
        check("rst fail_ledr", 32'(fail_ledr), 32'd0);
        @(negedge clk);
        check("rst stays idle", 32'(busy), 32'd0);
        mode = 0;
        pulse_start();
        wait_done(8192, -1, "post-rst");
        check("post-rst pass", 32'(pass), 32'd1);
        check("post-rst err_cnt", 32'(err_cnt), 32'd0);

        // Upper status bit set on equality: bits [15:10] are always compared.
        mode = 2;
        pulse_start();
        wait_done(STOP ? 7172 : 8192, -1, "hi-bit");
        check("hi-bit err_cnt", 32'(err_cnt), STOP ? 32'd1 : 32'd256);
        check("hi-bit pass", 32'(pass), 32'd0);
        check("hi-bit fail_sw", 32'(fail_sw), 32'h0700);
        check("hi-bit fail_ledr", 32'(fail_ledr), 32'h8040);

        // Garbage only in masked-off bits must not count.
        mode = 3;
        pulse_start();
        wait_done(8192, -1, "dontcare");
        check("dontcare err_cnt", 32'(err_cnt), 32'd0);
        check("dontcare pass", 32'(pass), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
